cnt_ud: RTL and testbench
=========================

Name: cnt_ud

Overview:
- Parameterised binary up/down counter with terminal-count detect and automatic reload from a data input.
- Generic sequential building block for timers, prescalers and periodic tick generators.
- Counts toward the terminal value for the selected direction. At the terminal value it flags `tc` and reloads `d` on the next edge, giving a programmable period.

Parameters:
- LEN, default 4, counter and reload-data width in bits; legal range LEN >= 1.

Ports:
- clk, input, 1, system clock; all state changes on rising edge.
- rst, input, 1, synchronous active-low reset (0 = reset), sampled on rising edge of clk.
- u_dn, input, 1, direction select: 1 = count up, 0 = count down.
- d, input, LEN, reload value loaded when terminal count is reached.
- q, output, LEN, current count, registered.
- tc, output, 1, terminal-count flag, combinational from q and u_dn.

Behaviour:
- Reset and clocking:
  - One clock domain; reset is synchronous and active-low. rst=0 at a rising edge forces q <= 0.
  - No asynchronous path; reset dominates all other activity.
- Terminal value:
  - Up mode (u_dn=1): terminal is all-ones, 2^LEN-1.
  - Down mode (u_dn=0): terminal is 0.
- tc:
  - tc = (u_dn ? q == all-ones : q == 0). Purely combinational, no latency.
  - tc is valid during reset too: in reset q=0, so tc=1 when u_dn=0 and tc=0 when u_dn=1.
- Next-state rule when rst=1, evaluated each rising edge:
  - tc=1: q <= d (reload).
  - else u_dn=1: q <= q + 1.
  - else: q <= q - 1.
- Arithmetic is LEN-bit modulo. Wrap never happens through increment/decrement because the terminal value always reloads instead.
- Period:
  - Down mode: d+1 cycles (d, d-1, ..., 0).
  - Up mode: (2^LEN-1) - d + 1 cycles (d, ..., all-ones).
  - d=0 in down mode: q stays 0, tc stuck high.
  - d=all-ones in up mode: q stays all-ones, tc stuck high.
- Reload value outside the counting range:
  - Up mode, d above current q: no effect until terminal is reached.
  - Direction change mid-count: q immediately steps in the new direction on the next edge. tc re-evaluates combinationally against the new terminal.
- d is sampled only on the reload edge; changes at other times have no effect.
- Reset mid-operation: q returns to 0 on the next edge regardless of count or direction. Counting resumes from 0 on the first edge with rst=1. In down mode this first edge reloads d.
- Out-of-range or X inputs: no internal protection; behaviour follows the rule above.

Optional Feature:
- Macro CNT_UD_CHECK_EN.
- When defined, simulation-only checks are compiled in (excluded from synthesis):
  - Error message if u_dn or rst is X/Z at a rising edge.
  - Error message if d is X/Z on a reload edge.
  - Error message if LEN < 1 at elaboration.
- When undefined, no checking logic exists; RTL function and ports are identical.

Test Plan:
- Reset: rst=0, u_dn=0, d=10, run 2 edges -> q=0, tc=1. Switch u_dn=1 while still in reset -> q=0, tc=0.
- Down count: release rst, d=3, u_dn=0 -> q sequence 3,2,1,0,3,2,1,0. tc=1 exactly when q=0, period 4 cycles.
- Up count (LEN=4): reset, release, d=5, u_dn=1 -> q 1,2,...,15,5,6,...,15,5. tc=1 only at q=15, steady-state period 11.
- Direction change: up count reaches q=7, set u_dn=0 -> next q=6, then 5...0, reload d. tc follows the new terminal combinationally.
- Reset mid-count: at q=9 (up mode) drive rst=0 for one edge -> q=0 on that edge. After release, counts 1,2,... from 0.
- Degenerate reload: u_dn=0, d=0 -> q held at 0, tc constantly 1. u_dn=1, d=15 -> q held at 15, tc constantly 1.

Source files
------------

// File: rtl/cnt_ud.sv
// Up/down counter with terminal-count detect and automatic reload from d.
// Optional simulation-only input checks are enabled with CNT_UD_CHECK_EN.
module cnt_ud #(
  parameter int LEN = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           u_dn,
  input  logic [LEN-1:0] d,
  output logic [LEN-1:0] q,
  output logic           tc
);

  localparam logic [LEN-1:0] ALL_ONES = '1;
  localparam logic [LEN-1:0] ONE      = LEN'(1);

  logic [LEN-1:0] q_next;

  // The terminal value depends on direction, so tc follows a u_dn change immediately.
  assign tc = u_dn ? (q == ALL_ONES) : (q == '0);

  always_comb begin
    // NOTE: give q_next a value before any branch so no path can infer a latch.
    q_next = q;
    if (tc) begin
      q_next = d;
    end else if (u_dn) begin
      q_next = q + ONE;
    end else begin
      q_next = q - ONE;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignment so every flop samples pre-edge values.
    if (!rst) begin
      q <= '0;
    end else begin
      q <= q_next;
    end
  end

`ifdef CNT_UD_CHECK_EN
  if (LEN < 1) begin : g_bad_len
    $error("cnt_ud: LEN must be >= 1 (got %0d)", LEN);
  end

  always @(posedge clk) begin
    if ($isunknown(u_dn) || $isunknown(rst)) begin
      $error("cnt_ud: u_dn or rst is X/Z at a rising edge");
    end
    if (rst === 1'b1 && tc === 1'b1 && $isunknown(d)) begin
      $error("cnt_ud: d is X/Z on a reload edge");
    end
  end
`endif

endmodule

// File: tb/tb_cnt_ud.sv
// Self-checking bench for cnt_ud (LEN=4): vector table, corner-case sequences
// and randomized stimulus against an arithmetic reference model.
module tb_cnt_ud;

  localparam int LEN = 4;
  localparam int MAXV = (1 << LEN) - 1;

  logic           clk = 1'b0;
  logic           rst;
  logic           u_dn;
  logic [LEN-1:0] d;
  logic [LEN-1:0] q;
  logic           tc;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic r;
    logic u;
    int   dv;
    int   exp_q;
    logic exp_tc;
  } vec_t;

  vec_t vecs[$];

  cnt_ud #(.LEN(LEN)) dut (
    .clk  (clk),
    .rst  (rst),
    .u_dn (u_dn),
    .d    (d),
    .q    (q),
    .tc   (tc)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drive inputs on the falling edge, let one rising edge pass, sample 1 ns later.
  task automatic apply(input logic r, input logic u, input int dv);
    @(negedge clk);
    rst  = r;
    u_dn = u;
    d    = LEN'(dv);
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input string name, input int eq, input logic etc);
    check({name, " q"}, int'(q), eq);
    check({name, " tc"}, int'(tc), int'(etc));
  endtask

  task automatic push(input logic r, input logic u, input int dv, input int eq, input logic etc);
    vec_t v;
    v.r = r; v.u = u; v.dv = dv; v.exp_q = eq; v.exp_tc = etc;
    vecs.push_back(v);
  endtask

  // Reference: one edge of the counter described as terminal/reload/step arithmetic.
  function automatic int model_next(input int cur, input logic r, input logic u, input int dv);
    int term;
    if (!r) return 0;
    term = u ? MAXV : 0;
    if (cur == term) return dv;
    return (cur + (u ? 1 : -1)) & MAXV;
  endfunction

  initial begin
    int mq;
    logic ru, rr;
    int rd;

    rst = 1'b0; u_dn = 1'b0; d = '0;

    // Reset behaviour.
    push(0, 0, 10, 0, 1);
    push(0, 0, 10, 0, 1);
    push(0, 1, 10, 0, 0);
    // Down count d=3: first edge reloads from 0.
    for (int k = 0; k < 2; k++) begin
      push(1, 0, 3, 3, 0);
      push(1, 0, 3, 2, 0);
      push(1, 0, 3, 1, 0);
      push(1, 0, 3, 0, 1);
    end
    // Up count d=5 from reset.
    push(0, 1, 5, 0, 0);
    for (int i = 1; i <= MAXV; i++) push(1, 1, 5, i, i == MAXV);
    for (int i = 5; i <= MAXV; i++) push(1, 1, 5, i, i == MAXV);
    push(1, 1, 5, 5, 0);

    foreach (vecs[i]) begin
      apply(vecs[i].r, vecs[i].u, vecs[i].dv);
      expect_state($sformatf("vec%0d", i), vecs[i].exp_q, vecs[i].exp_tc);
    end

    // Direction change at q=7, then reload d=9 after reaching 0.
    apply(0, 1, 9);
    for (int i = 1; i <= 7; i++) apply(1, 1, 9);
    expect_state("dir up7", 7, 0);
    @(negedge clk);
    u_dn = 1'b0;
    #1;
    check("dir tc after switch", int'(tc), 0);
    @(posedge clk); #1;
    expect_state("dir down6", 6, 0);
    for (int i = 5; i >= 0; i--) begin
      apply(1, 0, 9);
      expect_state($sformatf("dir down%0d", i), i, i == 0);
    end
    @(negedge clk);
    u_dn = 1'b1;
    #1;
    check("dir tc at 0 up", int'(tc), 0);
    u_dn = 1'b0;
    #1;
    check("dir tc at 0 down", int'(tc), 1);
    @(posedge clk); #1;
    expect_state("dir reload", 9, 0);

    // Reset mid-count at q=9 in up mode.
    apply(0, 1, 0);
    for (int i = 1; i <= 9; i++) apply(1, 1, 0);
    expect_state("mid q9", 9, 0);
    apply(0, 1, 0);
    expect_state("mid reset", 0, 0);
    apply(1, 1, 0);
    expect_state("mid resume1", 1, 0);
    apply(1, 1, 0);
    expect_state("mid resume2", 2, 0);

    // Degenerate reloads.
    apply(0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      apply(1, 0, 0);
      expect_state($sformatf("deg down%0d", i), 0, 1);
    end
    for (int i = 1; i <= MAXV; i++) apply(1, 1, MAXV);
    for (int i = 0; i < 4; i++) begin
      apply(1, 1, MAXV);
      expect_state($sformatf("deg up%0d", i), MAXV, 1);
    end

    // Randomized run against the reference model.
    apply(0, 0, 0);
    mq = 0;
    ru = 1'b0;
    for (int i = 0; i < 400; i++) begin
      rr = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 9) == 0) ru = ~ru;
      rd = int'($urandom_range(0, MAXV));
      apply(rr, ru, rd);
      mq = model_next(mq, rr, ru, rd);
      expect_state($sformatf("rnd%0d", i), mq, ru ? (mq == MAXV) : (mq == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
